// File: rtl/bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bp_pkg                                                     |
// | Brief   : Shared counter encodings, defaults and update helper for   |
// |           the 2-bit branch predictor.                                |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package bp_pkg;

    typedef enum logic [1:0] {
        c_CTR_SNT = 2'b00,
        c_CTR_WNT = 2'b01,
        c_CTR_WT  = 2'b10,
        c_CTR_ST  = 2'b11
    } ctrState_e;

    localparam int unsigned c_DEFAULT_IDX_BITS   = 4;
    localparam logic [1:0]  c_DEFAULT_INIT_STATE = 2'b01;

    function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != c_CTR_ST)) begin
            nxt = ctr + 2'd1;
        end else if (!taken && (ctr != c_CTR_SNT)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bht_table                                                  |
// | Brief   : Array of 2-bit saturating counters, one read port and one  |
// |           write (update) port; reads see the pre-update value.       |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module bht_table
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS   = c_DEFAULT_IDX_BITS,
    parameter logic [1:0]  INIT_STATE = c_DEFAULT_INIT_STATE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] i_rdIdx,
    output logic [1:0]          o_rdCtr,
    input  logic                i_wrEn,
    input  logic [IDX_BITS-1:0] i_wrIdx,
    input  logic                i_wrTaken
);

    localparam int unsigned c_DEPTH = 1 << IDX_BITS;

    logic [1:0] r_counters [c_DEPTH];

    assign o_rdCtr = r_counters[i_rdIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < c_DEPTH; i++) begin
                r_counters[i] <= INIT_STATE;
            end
        end else if (i_wrEn) begin
            r_counters[i_wrIdx] <= satUpdate(r_counters[i_wrIdx], i_wrTaken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_predictor                                           |
// | Brief   : Decode-stage 2-bit dynamic branch predictor with execute-  |
// |           stage resolution, PC redirect and statistics counters.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS   = c_DEFAULT_IDX_BITS,
    parameter logic [1:0]  INIT_STATE = c_DEFAULT_INIT_STATE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iBranch_RegD,
    input  logic [31:0] iPC_RegD,
    input  logic [31:0] iTarget_RegD,
    input  logic        iStall_Dec,
    input  logic        iBranch_RegE,
    input  logic        iZero_RegE,
    output logic [1:0]  obranch_predict,
    output logic        oPCRedirect,
    output logic [31:0] oPCTarget,
    output logic [15:0] ocnt_branch,
    output logic [15:0] ocnt_miss
);

    logic                r_deValid;
    logic                r_dePred;
    logic [IDX_BITS-1:0] r_deIdx;
    logic [31:0]         r_deAltPc;
    logic [15:0]         r_cntBranch;
    logic [15:0]         r_cntMiss;

    logic [IDX_BITS-1:0] w_rdIdx;
    logic [1:0]          w_rdCtr;
    logic                w_resolve;
    logic                w_mispredict;
    logic                w_predictTaken;

    assign w_rdIdx = iPC_RegD[IDX_BITS+1:2];

    bht_table #(
        .IDX_BITS   (IDX_BITS),
        .INIT_STATE (INIT_STATE)
    ) uBht (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rdIdx   (w_rdIdx),
        .o_rdCtr   (w_rdCtr),
        .i_wrEn    (w_resolve),
        .i_wrIdx   (r_deIdx),
        .i_wrTaken (iZero_RegE)
    );

    assign w_resolve    = r_deValid & iBranch_RegE;
    assign w_mispredict = w_resolve & (iZero_RegE != r_dePred);
    // rst_n gating keeps the outputs quiet even if INIT_STATE predicts taken
    assign w_predictTaken = rst_n & iBranch_RegD & w_rdCtr[1] & ~iStall_Dec & ~w_mispredict;

    assign obranch_predict = {w_mispredict, w_predictTaken};
    assign oPCRedirect     = w_mispredict | w_predictTaken;
    assign oPCTarget       = w_mispredict ? r_deAltPc : iTarget_RegD;
    assign ocnt_branch     = r_cntBranch;
    assign ocnt_miss       = r_cntMiss;

    // The stored alternate PC is the path not taken by the prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deValid <= 1'b0;
            r_dePred  <= 1'b0;
            r_deIdx   <= '0;
            r_deAltPc <= '0;
        end else if (iStall_Dec || w_mispredict) begin
            r_deValid <= 1'b0;
        end else begin
            r_deValid <= iBranch_RegD;
            r_dePred  <= w_predictTaken;
            r_deIdx   <= w_rdIdx;
            r_deAltPc <= w_predictTaken ? (iPC_RegD + 32'd4) : iTarget_RegD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntBranch <= '0;
            r_cntMiss   <= '0;
        end else begin
            if (w_resolve && (r_cntBranch != 16'hFFFF)) begin
                r_cntBranch <= r_cntBranch + 16'd1;
            end
            if (w_mispredict && (r_cntMiss != 16'hFFFF)) begin
                r_cntMiss <= r_cntMiss + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_branch_predictor                                        |
// | Brief   : Scoreboard bench for branch_predictor with directed vectors|
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_predictor;

    typedef struct packed {
        logic [1:0]  pred;
        logic [31:0] tgt;
        logic [15:0] nBr;
        logic [15:0] nMiss;
        logic        ctrChk;
        logic [3:0]  ctrIdx;
        logic [1:0]  ctr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        bD;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        stall;
    logic        bE;
    logic        zero;
    logic [1:0]  pred;
    logic        redir;
    logic [31:0] pcTgt;
    logic [15:0] cntBr;
    logic [15:0] cntMiss;

    exp_t  expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .iBranch_RegD    (bD),
        .iPC_RegD        (pc),
        .iTarget_RegD    (tgt),
        .iStall_Dec      (stall),
        .iBranch_RegE    (bE),
        .iZero_RegE      (zero),
        .obranch_predict (pred),
        .oPCRedirect     (redir),
        .oPCTarget       (pcTgt),
        .ocnt_branch     (cntBr),
        .ocnt_miss       (cntMiss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExp(input string nm, input logic [1:0] ePred, input logic [31:0] eTgt,
                           input logic [15:0] eBr, input logic [15:0] eMiss,
                           input int cIdx, input logic [1:0] eCtr);
        exp_t e;
        e.pred   = ePred;
        e.tgt    = eTgt;
        e.nBr    = eBr;
        e.nMiss  = eMiss;
        e.ctrChk = (cIdx >= 0);
        e.ctrIdx = (cIdx >= 0) ? cIdx[3:0] : 4'd0;
        e.ctr    = eCtr;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // One clock cycle of stimulus; the expected response goes to the scoreboard
    task automatic cyc(input string nm, input logic iBD, input logic [31:0] iPc, input logic [31:0] iTgt,
                       input logic iSt, input logic iBE, input logic iZr,
                       input logic [1:0] ePred, input logic [31:0] eTgt,
                       input logic [15:0] eBr, input logic [15:0] eMiss,
                       input int cIdx, input logic [1:0] eCtr);
        @(posedge clk);
        #1;
        bD    = iBD;
        pc    = iPc;
        tgt   = iTgt;
        stall = iSt;
        bE    = iBE;
        zero  = iZr;
        pushExp(nm, ePred, eTgt, eBr, eMiss, cIdx, eCtr);
    endtask

    // Monitor: samples between edges and on an asynchronous reset assertion
    initial begin
        exp_t  e;
        string nm;
        logic [1:0] actCtr;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                checks++;
                if (pred !== e.pred || redir !== (e.pred[0] | e.pred[1])) begin
                    errors++;
                    $display("FAIL %s predict: got pred=%b redirect=%b, expected pred=%b redirect=%b",
                             nm, pred, redir, e.pred, e.pred[0] | e.pred[1]);
                end
                checks++;
                if (pcTgt !== e.tgt) begin
                    errors++;
                    $display("FAIL %s target: got %h, expected %h", nm, pcTgt, e.tgt);
                end
                checks++;
                if (cntBr !== e.nBr || cntMiss !== e.nMiss) begin
                    errors++;
                    $display("FAIL %s counts: got branch=%h miss=%h, expected branch=%h miss=%h",
                             nm, cntBr, cntMiss, e.nBr, e.nMiss);
                end
                if (e.ctrChk) begin
                    actCtr = dut.uBht.r_counters[e.ctrIdx];
                    checks++;
                    if (actCtr !== e.ctr) begin
                        errors++;
                        $display("FAIL %s counter[%0d]: got %b, expected %b", nm, e.ctrIdx, actCtr, e.ctr);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bD = 0; pc = 0; tgt = 32'h1234; stall = 0; bE = 0; zero = 0;

        // reset holds outputs quiet
        cyc("rst0", 1, 32'h40, 32'h80,   0, 0, 0, 2'b00, 32'h80,   0, 0, 0, 2'b01);
        cyc("rst1", 0, 32'h0,  32'h1234, 0, 1, 1, 2'b00, 32'h1234, 0, 0, 0, 2'b01);
        @(negedge clk); #2 rst_n = 1'b1;

        // branch 0x40 -> 0x80, learned taken
        cyc("t1dec", 1, 32'h40, 32'h80, 0, 0, 0, 2'b00, 32'h80, 0, 0, 0, 2'b01);
        cyc("t1res", 0, 32'h0,  32'h0,  0, 1, 1, 2'b10, 32'h80, 0, 0, 0, 2'b01);
        cyc("t2dec", 1, 32'h40, 32'h80, 0, 0, 0, 2'b01, 32'h80, 1, 1, 0, 2'b10);
        cyc("t2res", 0, 32'h0,  32'h0,  0, 1, 1, 2'b00, 32'h0,  1, 1, 0, 2'b10);
        cyc("t3dec", 1, 32'h40, 32'h80, 0, 0, 0, 2'b01, 32'h80, 2, 1, 0, 2'b11);

        // strongly taken resolved not-taken
        cyc("ntres", 0, 32'h0, 32'h0, 0, 1, 0, 2'b10, 32'h44, 2, 1, 0, 2'b11);
        cyc("ntidl", 0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 32'h0,  3, 2, 0, 2'b10);

        // stalled decode neither predicts nor enters the stage
        cyc("stl",   1, 32'h40, 32'h80, 1, 0, 0, 2'b00, 32'h80, 3, 2, -1, 2'b00);
        cyc("stlE",  0, 32'h0,  32'h0,  0, 1, 1, 2'b00, 32'h0,  3, 2, -1, 2'b00);
        cyc("stlI",  0, 32'h0,  32'h0,  0, 0, 0, 2'b00, 32'h0,  3, 2, 0, 2'b10);

        // mispredict in E beats predicted-taken branch in D
        cyc("mpD",   1, 32'h44, 32'h100, 0, 0, 0, 2'b00, 32'h100, 3, 2, 1, 2'b01);
        cyc("mpE",   1, 32'h40, 32'h80,  0, 1, 1, 2'b10, 32'h100, 3, 2, 0, 2'b10);
        cyc("mpDrop",0, 32'h0,  32'h0,   0, 1, 0, 2'b00, 32'h0,   4, 3, -1, 2'b00);
        cyc("mpIdl", 0, 32'h0,  32'h0,   0, 0, 0, 2'b00, 32'h0,   4, 3, 1, 2'b10);

        // counter saturation at 00
        cyc("satD",  1, 32'h48, 32'h200, 0, 0, 0, 2'b00, 32'h200, 4, 3, 2, 2'b01);
        for (int k = 0; k < 6; k++) begin
            cyc("satR", 1, 32'h48, 32'h200, 0, 1, 0, 2'b00, 32'h200, 16'(4 + k), 3, 2,
                (k == 0) ? 2'b01 : 2'b00);
        end
        cyc("satL",  0, 32'h0, 32'h0, 0, 1, 0, 2'b00, 32'h0, 10, 3, 2, 2'b00);
        cyc("satI",  0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 32'h0, 11, 3, 2, 2'b00);

        // branch statistics counter saturates at FFFF
        @(negedge clk); #2;
        force dut.r_cntBranch = 16'hFFFF;
        #1;
        release dut.r_cntBranch;
        cyc("ffD",   1, 32'h48, 32'h200, 0, 0, 0, 2'b00, 32'h200, 16'hFFFF, 3, -1, 2'b00);
        cyc("ffR",   0, 32'h0,  32'h0,   0, 1, 0, 2'b00, 32'h0,   16'hFFFF, 3, -1, 2'b00);
        cyc("ffI",   0, 32'h0,  32'h0,   0, 0, 0, 2'b00, 32'h0,   16'hFFFF, 3, 2, 2'b00);

        // asynchronous reset while a mispredict is being resolved
        cyc("arD",   1, 32'h4C, 32'h300, 0, 0, 0, 2'b00, 32'h300, 16'hFFFF, 3, 3, 2'b01);
        cyc("arE",   0, 32'h0,  32'h0,   0, 1, 1, 2'b10, 32'h300, 16'hFFFF, 3, 0, 2'b10);
        @(negedge clk); #2;
        pushExp("arNow", 2'b00, 32'h0, 0, 0, 0, 2'b01);
        rst_n = 1'b0;
        cyc("arHold", 0, 32'h0, 32'h500, 0, 1, 1, 2'b00, 32'h500, 0, 0, 3, 2'b01);
        @(negedge clk); #2 rst_n = 1'b1;
        cyc("arRel",  0, 32'h0, 32'h0, 0, 1, 1, 2'b00, 32'h0, 0, 0, 3, 2'b01);
        cyc("arIdl",  0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 3, 2'b01);

        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
